// File: rtl/multicycle_datapath.sv
// Accumulating datapath driven by the multicycle control unit: R = A +/- B +/- C +/- D
// over four clocked steps, with sticky overflow and control-sequence checking.
module multicycle_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_valid,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  input  logic             add_or_sub,
  input  logic             done,
  input  logic             opnd_wr,
  input  logic [1:0]       opnd_sel,
  input  logic [WIDTH-1:0] opnd_data,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             ovf,
  output logic             busy,
  output logic             proto_err,
  output logic             wr_err
);

  localparam int unsigned CNT_W = 3;

  logic [WIDTH-1:0] a, b, c, d, acc;
  logic [CNT_W-1:0] step_cnt;

  logic [WIDTH-1:0] op_c, eff_c, sum_c;
  logic [CNT_W-1:0] expect_c;
  logic             illegal_c, ovf_c;

  // Operand select, expected step position and add/subtract with overflow detect
  always_comb begin
    op_c      = b;
    expect_c  = CNT_W'(1);
    illegal_c = 1'b0;
    case ({s2, s1})
      2'b00:   begin op_c = b; expect_c = CNT_W'(1); end
      2'b01:   begin op_c = c; expect_c = CNT_W'(2); end
      2'b10:   begin op_c = d; expect_c = CNT_W'(3); end
      default: illegal_c = 1'b1;
    endcase
    eff_c = add_or_sub ? op_c : ~op_c;
    sum_c = acc + eff_c + {{(WIDTH-1){1'b0}}, ~add_or_sub};
    ovf_c = (acc[WIDTH-1] == eff_c[WIDTH-1]) && (sum_c[WIDTH-1] != acc[WIDTH-1]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a            <= '0;
      b            <= '0;
      c            <= '0;
      d            <= '0;
      acc          <= '0;
      result       <= '0;
      step_cnt     <= '0;
      result_valid <= 1'b0;
      ovf          <= 1'b0;
      busy         <= 1'b0;
      proto_err    <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      wr_err       <= 1'b0;

      // done outranks any step presented in the same cycle
      if (done) begin
        if (busy) begin
          result       <= acc;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          step_cnt     <= '0;
          if (step_cnt != CNT_W'(4)) proto_err <= 1'b1;
        end
      end else if (ctrl_valid) begin
        if (!s0) begin
          acc       <= a;
          step_cnt  <= CNT_W'(1);
          busy      <= 1'b1;
          ovf       <= 1'b0;
          proto_err <= 1'b0;
        end else if (illegal_c || (step_cnt != expect_c)) begin
          proto_err <= 1'b1;
        end else begin
          acc      <= sum_c;
          step_cnt <= step_cnt + CNT_W'(1);
          if (ovf_c) ovf <= 1'b1;
        end
      end

      // Operand registers are frozen while a sequence is running
      if (opnd_wr) begin
        if (busy) begin
          wr_err <= 1'b1;
        end else begin
          case (opnd_sel)
            2'd0:    a <= opnd_data;
            2'd1:    b <= opnd_data;
            2'd2:    c <= opnd_data;
            default: d <= opnd_data;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath with hand-computed results.
module tb_multicycle_datapath;

  localparam int unsigned WIDTH = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             ctrl_valid = 1'b0;
  logic             s0 = 1'b0, s1 = 1'b0, s2 = 1'b0, add_or_sub = 1'b0;
  logic             done = 1'b0;
  logic             opnd_wr = 1'b0;
  logic [1:0]       opnd_sel = 2'd0;
  logic [WIDTH-1:0] opnd_data = '0;
  logic [WIDTH-1:0] result;
  logic             result_valid, ovf, busy, proto_err, wr_err;

  int n_checks = 0;
  int n_fails  = 0;

  multicycle_datapath #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .ctrl_valid(ctrl_valid),
    .s0(s0), .s1(s1), .s2(s2), .add_or_sub(add_or_sub), .done(done),
    .opnd_wr(opnd_wr), .opnd_sel(opnd_sel), .opnd_data(opnd_data),
    .result(result), .result_valid(result_valid), .ovf(ovf), .busy(busy),
    .proto_err(proto_err), .wr_err(wr_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic p0, input logic p1, input logic p2, input logic padd);
    ctrl_valid = 1'b1; s0 = p0; s1 = p1; s2 = p2; add_or_sub = padd;
    tick();
    ctrl_valid = 1'b0;
  endtask

  task automatic load();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic finish_seq();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [WIDTH-1:0] data);
    opnd_wr = 1'b1; opnd_sel = sel; opnd_data = data;
    tick();
    opnd_wr = 1'b0;
  endtask

  task automatic wr_all(input logic [WIDTH-1:0] va, vb, vc, vd);
    wr(2'd0, va); wr(2'd1, vb); wr(2'd2, vc); wr(2'd3, vd);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_proto", proto_err, 0);
    check("rst_wr_err", wr_err, 0);

    // 10 + 20 + 5 - 3 = 32, done held two cycles
    wr_all(8'd10, 8'd20, 8'd5, 8'd3);
    load();
    check("t1_busy", busy, 1);
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 1, 0);
    done = 1'b1;
    tick();
    check("t1_result", result, 8'h20);
    check("t1_valid", result_valid, 1);
    check("t1_busy_clr", busy, 0);
    tick();
    done = 1'b0;
    check("t1_valid_once", result_valid, 0);
    check("t1_ovf", ovf, 0);
    check("t1_proto", proto_err, 0);

    // 10 - 20 + 5 + 3 = -2
    load();
    step(1, 0, 0, 0); step(1, 1, 0, 1); step(1, 0, 1, 1);
    finish_seq();
    check("t2_result", result, 8'hFE);
    check("t2_ovf", ovf, 0);

    // 100 + 50 overflows to 0x96
    wr_all(8'd100, 8'd50, 8'd0, 8'd0);
    load();
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 1, 1);
    finish_seq();
    check("t3_result", result, 8'h96);
    check("t3_ovf", ovf, 1);
    load();
    check("t3_ovf_clr", ovf, 0);
    finish_seq();

    // C skipped: D step ignored
    wr_all(8'd10, 8'd20, 8'd5, 8'd3);
    load();
    check("t4_proto_clr", proto_err, 0);
    step(1, 0, 0, 1); step(1, 0, 1, 1);
    check("t4_proto", proto_err, 1);
    finish_seq();
    check("t4_result", result, 8'h1E);
    check("t4_proto_stay", proto_err, 1);

    // write while busy rejected, illegal encoding holds acc
    load();
    wr(2'd1, 8'h55);
    check("t5_wr_err", wr_err, 1);
    tick();
    check("t5_wr_err_pulse", wr_err, 0);
    step(1, 0, 0, 1);
    check("t5_proto_pre", proto_err, 0);
    step(1, 1, 1, 1);
    check("t5_proto_illegal", proto_err, 1);
    finish_seq();
    check("t5_result", result, 8'h1E);

    // write A and LOAD together: LOAD takes old A, write lands
    opnd_wr = 1'b1; opnd_sel = 2'd0; opnd_data = 8'd7;
    load();
    opnd_wr = 1'b0;
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 1, 1);
    finish_seq();
    check("t6_old_a", result, 8'h26);
    check("t6_proto", proto_err, 0);
    load();
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 0, 1, 1);
    finish_seq();
    check("t6_new_a", result, 8'h23);

    // reset mid-sequence, then a lone done
    load();
    step(1, 0, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t7_result", result, 0);
    check("t7_busy", busy, 0);
    check("t7_ovf", ovf, 0);
    check("t7_proto", proto_err, 0);
    finish_seq();
    check("t7_no_valid", result_valid, 0);
    check("t7_result_hold", result, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
